// File: rtl/resp_delay_queue.sv
// resp_delay_queue
//   Holds every response coming back from the simulated receiver in an
//   in-order FIFO and hands each one to the transport engine only once a
//   fixed return-path delay has passed since it was captured. The return
//   link has finite buffering: a response arriving while the queue is full
//   is dropped, counted, and flagged by a sticky overflow bit.
//
// Ports
//   clk, rst                     clock; asynchronous active-high reset
//   resp_fid/pkt_type/pkt_data   response from the receiver (NONE_PKT = idle)
//   out_valid/out_ready          release handshake towards the engine
//   out_fid/pkt_type/pkt_data    head entry fields (idle values when !out_valid)
//   occupancy                    entries currently held
//   drop_cnt                     saturating count of responses dropped on full
//   overflow                     sticky, set on the first drop

`ifndef FLOW_ID_W
`define FLOW_ID_W 8
`endif
`ifndef PKT_TYPE_W
`define PKT_TYPE_W 4
`endif
`ifndef PKT_DATA_W
`define PKT_DATA_W 32
`endif
`ifndef NONE_PKT
`define NONE_PKT 4'd0
`endif
`ifndef FLOW_ID_NONE
`define FLOW_ID_NONE 8'hFF
`endif

module resp_delay_queue #(
  parameter int DEPTH = 16,
  parameter int DELAY = 8,
  parameter int TS_W  = 16,
  parameter int CNT_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [`FLOW_ID_W-1:0]     resp_fid,
  input  logic [`PKT_TYPE_W-1:0]    resp_pkt_type,
  input  logic [`PKT_DATA_W-1:0]    resp_pkt_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [`FLOW_ID_W-1:0]     out_fid,
  output logic [`PKT_TYPE_W-1:0]    out_pkt_type,
  output logic [`PKT_DATA_W-1:0]    out_pkt_data,
  output logic [$clog2(DEPTH):0]    occupancy,
  output logic [CNT_W-1:0]          drop_cnt,
  output logic                      overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  logic [TS_W-1:0]         now;
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [OW-1:0]           occ;

  logic [`FLOW_ID_W-1:0]   fid_mem  [DEPTH];
  logic [`PKT_TYPE_W-1:0]  type_mem [DEPTH];
  logic [`PKT_DATA_W-1:0]  data_mem [DEPTH];
  logic [TS_W-1:0]         ts_mem   [DEPTH];

  logic [TS_W-1:0]         head_age;
  logic                    head_due;
  logic                    full;
  logic                    push_req;
  logic                    push_ok;
  logic                    pop;

  // Age is taken modulo 2^TS_W, so a wrap of now between capture and
  // release still yields the true elapsed cycle count.
  assign head_age  = now - ts_mem[rd_ptr];
  assign head_due  = head_age >= TS_W'(DELAY);
  assign out_valid = (occ != '0) && head_due;

  assign full      = (occ == OW'(DEPTH));
  assign pop       = out_valid && out_ready;
  assign push_req  = (resp_pkt_type != `NONE_PKT);
  // A pop on the same edge frees the slot the push needs, even when full.
  assign push_ok   = push_req && (!full || pop);

  assign out_fid      = out_valid ? fid_mem[rd_ptr]  : `FLOW_ID_NONE;
  assign out_pkt_type = out_valid ? type_mem[rd_ptr] : `NONE_PKT;
  assign out_pkt_data = out_valid ? data_mem[rd_ptr] : '0;
  assign occupancy    = occ;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      now      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      now <= now + TS_W'(1);
      if (push_ok)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
      if (push_req && !push_ok) begin
        overflow <= 1'b1;
        if (drop_cnt != '1)
          drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end
  end

  // Storage is not reset: an entry is only ever read after being written.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fid_mem[wr_ptr]  <= resp_fid;
      type_mem[wr_ptr] <= resp_pkt_type;
      data_mem[wr_ptr] <= resp_pkt_data;
      ts_mem[wr_ptr]   <= now;
    end
  end

endmodule

// File: tb/tb_resp_delay_queue.sv
// Bench for resp_delay_queue: a primary instance (DEPTH=16, DELAY=8,
// TS_W=16) driven with directed and random traffic under backpressure,
// and a second instance (DEPTH=4, DELAY=3, TS_W=4) fed the same responses
// with the engine always ready, so its timestamp wraps every 16 cycles.

`ifndef FLOW_ID_W
`define FLOW_ID_W 8
`endif
`ifndef PKT_TYPE_W
`define PKT_TYPE_W 4
`endif
`ifndef PKT_DATA_W
`define PKT_DATA_W 32
`endif
`ifndef NONE_PKT
`define NONE_PKT 4'd0
`endif
`ifndef FLOW_ID_NONE
`define FLOW_ID_NONE 8'hFF
`endif

module tb_resp_delay_queue;

  typedef struct packed {
    logic [7:0]  fid;
    logic [3:0]  typ;
    logic [31:0] data;
    logic [31:0] cap;
  } ent_t;

  logic        clk;
  logic        rst;
  logic [7:0]  resp_fid;
  logic [3:0]  resp_pkt_type;
  logic [31:0] resp_pkt_data;
  logic        out_ready;
  logic        ready1;

  logic        ov0, ov1;
  logic [7:0]  of0, of1;
  logic [3:0]  ot0, ot1;
  logic [31:0] od0, od1;
  logic [4:0]  occ0;
  logic [2:0]  occ1;
  logic [31:0] dc0, dc1;
  logic        ovf0, ovf1;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, one slot per instance
  ent_t sbq [2][$];
  int   cyc   [2];
  int   drops [2];
  int   ovfm  [2];
  int   dly   [2];
  int   dep   [2];

  resp_delay_queue #(.DEPTH(16), .DELAY(8), .TS_W(16), .CNT_W(32)) dut0 (
    .clk(clk), .rst(rst),
    .resp_fid(resp_fid), .resp_pkt_type(resp_pkt_type), .resp_pkt_data(resp_pkt_data),
    .out_valid(ov0), .out_ready(out_ready),
    .out_fid(of0), .out_pkt_type(ot0), .out_pkt_data(od0),
    .occupancy(occ0), .drop_cnt(dc0), .overflow(ovf0)
  );

  resp_delay_queue #(.DEPTH(4), .DELAY(3), .TS_W(4), .CNT_W(32)) dut1 (
    .clk(clk), .rst(rst),
    .resp_fid(resp_fid), .resp_pkt_type(resp_pkt_type), .resp_pkt_data(resp_pkt_data),
    .out_valid(ov1), .out_ready(ready1),
    .out_fid(of1), .out_pkt_type(ot1), .out_pkt_data(od1),
    .occupancy(occ1), .drop_cnt(dc1), .overflow(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int i, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", name, i, $time, act, exp);
    end
  endtask

  // Monitor and reference model: compare mid-cycle, then advance the model
  // across the coming rising edge using the inputs currently applied.
  initial begin
    dly[0] = 8; dep[0] = 16;
    dly[1] = 3; dep[1] = 4;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        logic        v, rdy, ev, pop;
        logic [7:0]  f;
        logic [3:0]  t;
        logic [31:0] d, dc;
        int          oc;
        logic        ovf;
        ent_t        e;
        if (i == 0) begin
          v = ov0; f = of0; t = ot0; d = od0; oc = int'(occ0); dc = dc0; ovf = ovf0; rdy = out_ready;
        end else begin
          v = ov1; f = of1; t = ot1; d = od1; oc = int'(occ1); dc = dc1; ovf = ovf1; rdy = ready1;
        end
        if (rst) begin
          sbq[i].delete();
          cyc[i] = 0; drops[i] = 0; ovfm[i] = 0;
          check("rst_valid", i, 64'(v), 64'd0);
          check("rst_occ", i, 64'(oc), 64'd0);
          check("rst_drop", i, 64'(dc), 64'd0);
          check("rst_ovf", i, 64'(ovf), 64'd0);
        end else begin
          ev = (sbq[i].size() != 0) && ((cyc[i] - int'(sbq[i][0].cap)) >= dly[i]);
          check("valid", i, 64'(v), 64'(ev));
          if (ev) begin
            check("fid", i, 64'(f), 64'(sbq[i][0].fid));
            check("type", i, 64'(t), 64'(sbq[i][0].typ));
            check("data", i, 64'(d), 64'(sbq[i][0].data));
          end else begin
            check("idle_fid", i, 64'(f), 64'(`FLOW_ID_NONE));
            check("idle_type", i, 64'(t), 64'(`NONE_PKT));
            check("idle_data", i, 64'(d), 64'd0);
          end
          check("occupancy", i, 64'(oc), 64'(sbq[i].size()));
          check("drop_cnt", i, 64'(dc), 64'(drops[i]));
          check("overflow", i, 64'(ovf), 64'(ovfm[i]));
          pop = ev && rdy;
          if (pop) void'(sbq[i].pop_front());
          if (resp_pkt_type != `NONE_PKT) begin
            if (sbq[i].size() < dep[i]) begin
              e.fid = resp_fid; e.typ = resp_pkt_type; e.data = resp_pkt_data; e.cap = 32'(cyc[i]);
              sbq[i].push_back(e);
            end else begin
              drops[i]++;
              ovfm[i] = 1;
            end
          end
          cyc[i]++;
        end
      end
    end
  end

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      resp_pkt_type = `NONE_PKT;
      resp_fid = 8'h00;
      resp_pkt_data = 32'h0;
    end
  endtask

  task automatic send(input logic [7:0] f, input logic [3:0] t, input logic [31:0] d);
    @(posedge clk); #1;
    resp_fid = f;
    resp_pkt_type = t;
    resp_pkt_data = d;
  endtask

  task automatic send_rand();
    send(8'($urandom), 4'($urandom_range(1, 15)), $urandom);
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    ready1 = 1'b1;
    resp_fid = 8'h00;
    resp_pkt_type = `NONE_PKT;
    resp_pkt_data = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single response: visible only in the cycle after capture edge + 7
    idle(4);
    send(8'd3, 4'd1, 32'h10);
    for (int j = 0; j < 10; j++) begin
      idle(1);
      check("single_valid", 0, 64'(ov0), 64'(j == 7));
      if (j == 7) check("single_fid", 0, 64'(of0), 64'd3);
    end
    check("single_occ", 0, 64'(occ0), 64'd0);

    // Back-to-back fids 1..5
    for (int k = 1; k <= 5; k++) send(8'(k), 4'd1, 32'(k * 16));
    idle(15);

    // Backpressure stall then release
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) send(8'(8'h20 + k), 4'd2, $urandom);
    idle(20);
    check("stall_valid", 0, 64'(ov0), 64'd1);
    check("stall_head", 0, 64'(of0), 64'h20);
    out_ready = 1'b1;
    idle(12);

    // Overflow: 20 responses into 16 slots with the engine stalled
    out_ready = 1'b0;
    for (int k = 0; k < 20; k++) send(8'(8'h40 + k), 4'd3, $urandom);
    idle(1);
    check("ovf_occ", 0, 64'(occ0), 64'd16);
    check("ovf_drop", 0, 64'(dc0), 64'd4);
    check("ovf_flag", 0, 64'(ovf0), 64'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    resp_fid = 8'h77; resp_pkt_type = 4'd4; resp_pkt_data = 32'hCAFE;
    idle(1);
    check("full_swap_occ", 0, 64'(occ0), 64'd16);
    check("full_swap_drop", 0, 64'(dc0), 64'd4);
    idle(30);

    // Reset in the middle of a stream
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) send(8'(8'h60 + k), 4'd5, $urandom);
    idle(10);
    rst = 1'b1;
    #1;
    check("async_valid", 0, 64'(ov0), 64'd0);
    check("async_occ", 0, 64'(occ0), 64'd0);
    check("async_drop", 0, 64'(dc0), 64'd0);
    check("async_ovf", 0, 64'(ovf0), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    idle(20);

    // Random traffic with random backpressure
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 99) < 60) send_rand();
      else idle(1);
      out_ready = ($urandom_range(0, 99) < 70);
    end
    out_ready = 1'b1;
    idle(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/resp_delay_queue.md
Name: resp_delay_queue

Overview:
- Sits directly downstream of the simulated receiver and upstream of the transport engine's response input.
- Captures every non-NONE response (fid, type, data), timestamps it, and holds it in an in-order FIFO.
- Releases each entry to the engine over a valid/ready handshake once a fixed return-path delay has elapsed.
- Models finite return-link buffering: overflow drops are counted and flagged.

Parameters:
- DEPTH, 16, FIFO entries; power of two, ≥2.
- DELAY, 8, minimum cycles from capture to eligibility; 1 ≤ DELAY < 2^TS_W.
- TS_W, 16, width of free-running cycle counter and stored timestamps.
- CNT_W, 32, width of drop counter.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- resp_fid  in  `FLOW_ID_W  response flow id from receiver.
- resp_pkt_type  in  `PKT_TYPE_W  response type; `NONE_PKT = no response this cycle.
- resp_pkt_data  in  `PKT_DATA_W  response payload.
- out_valid  out  1  head entry eligible.
- out_ready  in  1  engine accepts head this cycle.
- out_fid  out  `FLOW_ID_W  head flow id.
- out_pkt_type  out  `PKT_TYPE_W  head type.
- out_pkt_data  out  `PKT_DATA_W  head payload.
- occupancy  out  clogb2(DEPTH)+1  entries held.
- drop_cnt  out  CNT_W  responses dropped on full.
- overflow  out  1  sticky; set on first drop.

Behaviour:
- Reset (async assert, sync deassert use): now=0, wr/rd pointers=0, occupancy=0, drop_cnt=0, overflow=0, out_valid=0; FIFO contents don't-care.
- now: TS_W counter, +1 every cycle, wraps to 0 modulo 2^TS_W.
- Push: at edge where resp_pkt_type != `NONE_PKT:
  - If not full, or a pop occurs at the same edge, write {fid, type, data, ts=now-before-edge} at wr_ptr and advance it.
  - Otherwise drop: drop_cnt+1 (saturates at all-ones), overflow←1.
- Pop: at edge where out_valid && out_ready, advance rd_ptr.
- occupancy: +1 push only, −1 pop only, unchanged on both or neither.
- Eligibility (combinational from registered state): out_valid = (occupancy≠0) && ((now − ts_head) mod 2^TS_W ≥ DELAY).
  - A response sampled at edge k is first visible in the cycle after edge k+DELAY−1; DELAY=1 means visible the cycle after capture.
- Ordering: strictly FIFO. A later entry is never released before the head, even if independently eligible.
- Outputs when out_valid=0: out_fid=`FLOW_ID_NONE, out_pkt_type=`NONE_PKT, out_pkt_data=0. When out_valid=1: head fields.
- out_ready while out_valid=0: ignored.
- Held-off head (out_ready=0): out_valid stays 1 and the head stays stable until accepted. Wrap of now does not revoke eligibility as long as any entry waits < 2^TS_W − DELAY cycles; the bench never exceeds this.
- Full + push + pop same edge: push accepted, occupancy stays DEPTH, no drop.
- Empty: push and pop cannot coincide, since out_valid=0.
- Pointer wrap: pointers are clogb2(DEPTH) bits and wrap naturally; full = occupancy==DEPTH.
- Reset mid-operation: all entries discarded immediately. out_valid deasserts asynchronously, and no held response is delivered after reset release.
- Pure storage: no inspection or modification of fid, type or data.

Test Plan:
1. Single response, DELAY=8: fid=3, type=ACK, data=0x10 at edge 5, out_ready=1 → out_valid=1 only in the cycle after edge 12, fields match exactly, occupancy returns to 0.
2. Back-to-back responses, DELAY=4, fids 1..5 on consecutive edges, out_ready=1 → five consecutive out_valid cycles, fids in order 1..5, no gaps.
3. Backpressure: DELAY=2, 3 entries, out_ready=0 for 20 cycles then 1 → head fid stable and out_valid=1 throughout the stall; all 3 delivered in order on 3 consecutive edges after release.
4. Overflow: DEPTH=16, out_ready=0, 20 responses → occupancy=16, drop_cnt=4, overflow=1. Then with out_ready=1 and a concurrent push at full → push accepted, drop_cnt stays 4.
5. Timestamp wrap: TS_W=4, DELAY=3, response captured when now=14 → becomes eligible when now=1 (after wrap), not earlier.
6. Reset mid-stream: 6 entries queued, assert rst for 1 cycle → occupancy=0, out_valid=0, drop_cnt=0, overflow=0 immediately; no stale response appears after release.
